// File: rtl/arm_rf_pkg.sv
// Shared constants for the ARM64 integer register file: default geometry and the XZR index.
package arm_rf_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_NUM_RD = 4;
  localparam logic [4:0] XZR_IDX = 5'd31;
endpackage

// File: rtl/arm_rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on a same-index collision.
module arm_rf_scoreboard
  import arm_rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [DEPTH-1:0]  busy_nxt
);
  localparam logic [DEPTH-1:0] XZR_BIT = {1'b1, {(DEPTH-1){1'b0}}};
  localparam logic [DEPTH-1:0] LIVE    = (ZERO_REG != 0) ? ~XZR_BIT : {DEPTH{1'b1}};

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  assign set_vec = set_en ? (DEPTH'(1) << set_addr) : '0;
  assign clr_vec = clr_en ? (DEPTH'(1) << clr_addr) : '0;

  // Clear first, then set, so a new producer issued alongside the old writeback keeps the bit.
  assign busy_nxt = ((busy_vec & ~clr_vec) | set_vec) & LIVE;

  always_ff @(posedge clock) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busy_nxt;
  end
endmodule

// File: rtl/arm_reg_file_sb.sv
// ARM64 integer register file with N combinational read ports, one writeback port,
// optional writeback bypass, XZR handling and a busy scoreboard for RAW stalls.
module arm_reg_file_sb
  import arm_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == ZIDX));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == ZIDX));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  arm_rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (iss_ok),
    .set_addr (iss_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .busy_vec (busy_vec),
    .busy_nxt (busy_nxt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[p*ADDR_W +: ADDR_W];

    // A forwarded operand reports the post-writeback busy state, so only a same-cycle re-issue stalls.
    always_comb begin
      d = regs[a];
      b = busy_vec[a];
      if ((ZERO_REG != 0) && (a == ZIDX)) begin
        d = '0;
        b = 1'b0;
      end else if ((BYPASS != 0) && wb_en && (wb_addr == a)) begin
        d = wb_data;
        b = busy_nxt[a];
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = d;
    assign rd_busy[p] = b;
  end
endmodule
